// File: rtl/input_conditioner.sv
// input_conditioner: front-end for the raw board inputs.
// Synchronises the Execute/Peek pushbuttons and the data switches, debounces
// both keys with independent four-state FSMs, and produces a one-cycle Exec
// pulse, a clean Peek level (Pkb) and a synchronised switch word (DATA).
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       KEY_EXEb,
  input  logic       KEY_PKb,
  input  logic [9:0] SW,
  output logic       Exec,
  output logic       Pkb,
  output logic [9:0] DATA,
  output logic       KEY_ACTIVE
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // A change is accepted on the sample that brings the count to
  // DEBOUNCE_CYCLES-1, i.e. when the registered count already holds
  // DEBOUNCE_CYCLES-2. This makes acceptance land exactly
  // DEBOUNCE_CYCLES cycles after the synchronised key first changes.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

  localparam int unsigned EXE = 0;
  localparam int unsigned PK  = 1;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } db_state_e;

  logic [SYNC_STAGES-1:0] exe_sync_q;
  logic [SYNC_STAGES-1:0] pk_sync_q;
  logic [9:0]             sw_sync_q [SYNC_STAGES];

  logic [1:0]    key_s;
  db_state_e     state_q [2];
  db_state_e     state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];

  logic exec_q;
  logic pkb_q;
  logic active_q;

  // Input synchronisers; keys reset to released (1), switches to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_sync_q <= '1;
      pk_sync_q  <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= '0;
      end
    end else begin
      exe_sync_q   <= {exe_sync_q[SYNC_STAGES-2:0], KEY_EXEb};
      pk_sync_q    <= {pk_sync_q[SYNC_STAGES-2:0], KEY_PKb};
      sw_sync_q[0] <= SW;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_q[i-1];
      end
    end
  end

  assign key_s[EXE] = exe_sync_q[SYNC_STAGES-1];
  assign key_s[PK]  = pk_sync_q[SYNC_STAGES-1];

  // Debounce next-state logic for both keys; counter cleared on every state entry.
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        REL: begin
          if (!key_s[k]) begin
            state_d[k] = CHK_P;
            cnt_d[k]   = '0;
          end
        end
        CHK_P: begin
          if (key_s[k]) begin
            state_d[k] = REL;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == LAST) begin
            state_d[k] = PRS;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
        PRS: begin
          if (key_s[k]) begin
            state_d[k] = CHK_R;
            cnt_d[k]   = '0;
          end
        end
        CHK_R: begin
          if (!key_s[k]) begin
            state_d[k] = PRS;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == LAST) begin
            state_d[k] = REL;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
      endcase
    end
  end

  // Debounce state and counter registers.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 2; k++) begin
      if (rst) begin
        state_q[k] <= REL;
        cnt_q[k]   <= '0;
      end else begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Registered outputs, decoded from the next state so they change on the
  // same edge as the accepted transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_q   <= 1'b0;
      pkb_q    <= 1'b1;
      active_q <= 1'b0;
    end else begin
      exec_q   <= (state_q[EXE] == CHK_P) && (state_d[EXE] == PRS);
      pkb_q    <= !((state_d[PK] == PRS) || (state_d[PK] == CHK_R));
      active_q <= (state_d[EXE] == CHK_P) || (state_d[EXE] == CHK_R) ||
                  (state_d[PK]  == CHK_P) || (state_d[PK]  == CHK_R);
    end
  end

  assign Exec       = exec_q;
  assign Pkb        = pkb_q;
  assign KEY_ACTIVE = active_q;
  assign DATA       = sw_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed testbench for input_conditioner (DEBOUNCE_CYCLES=8, SYNC_STAGES=2).
// Inputs are driven on the falling edge and outputs sampled on the falling edge;
// cycle k means the k-th falling edge after the drive point.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       KEY_EXEb;
  logic       KEY_PKb;
  logic [9:0] SW;
  logic       Exec;
  logic       Pkb;
  logic [9:0] DATA;
  logic       KEY_ACTIVE;

  int n_checks = 0;
  int n_errors = 0;
  int n_exec   = 0;
  int exec_base;
  logic ka_seen;

  input_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .KEY_EXEb  (KEY_EXEb),
    .KEY_PKb   (KEY_PKb),
    .SW        (SW),
    .Exec      (Exec),
    .Pkb       (Pkb),
    .DATA      (DATA),
    .KEY_ACTIVE(KEY_ACTIVE)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Exec === 1'b1) n_exec++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with Execute held and all switches up.
    rst      = 1'b1;
    KEY_EXEb = 1'b0;
    KEY_PKb  = 1'b1;
    SW       = 10'h3FF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_exec@%0d", k), Exec, 1'b0);
      check($sformatf("rst_pkb@%0d", k), Pkb, 1'b1);
      check($sformatf("rst_data@%0d", k), DATA, 10'h000);
      check($sformatf("rst_active@%0d", k), KEY_ACTIVE, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_exec@%0d", k), Exec, k == 10);
      if (k == 1) check("post_rst_data@1", DATA, 10'h000);
      if (k == 2) check("post_rst_data@2", DATA, 10'h3FF);
    end
    KEY_EXEb = 1'b1;
    step(15);
    check("post_rst_release_active", KEY_ACTIVE, 1'b0);

    // DATA follows switches with two cycles of latency.
    SW = 10'h2A5;
    @(negedge clk);
    check("data_lat1", DATA, 10'h3FF);
    @(negedge clk);
    check("data_lat2", DATA, 10'h2A5);

    // Clean Execute press held 40 cycles: single pulse at cycle 10.
    exec_base = n_exec;
    KEY_EXEb  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("clean_exec@%0d", k), Exec, k == 10);
    end
    check("clean_pulse_count", n_exec - exec_base, 1);
    KEY_EXEb = 1'b1;
    step(15);

    // Bounce: 5 low / 3 high, four times; no pulse, KEY_ACTIVE during lows.
    exec_base = n_exec;
    for (int r = 0; r < 4; r++) begin
      KEY_EXEb = 1'b0;
      ka_seen  = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (KEY_ACTIVE === 1'b1) ka_seen = 1'b1;
      end
      KEY_EXEb = 1'b1;
      step(3);
      check($sformatf("bounce_active_seen%0d", r), ka_seen, 1'b1);
    end
    step(15);
    check("bounce_no_pulse", n_exec - exec_base, 0);
    check("bounce_idle_active", KEY_ACTIVE, 1'b0);

    // Peek hold with a 3-cycle release bounce; Pkb falls at 10, rises 10 after release.
    for (int k = 0; k < 40; k++) begin
      KEY_PKb = !((k < 12) || (k >= 15 && k < 20));
      @(negedge clk);
      check($sformatf("peek_pkb@%0d", k + 1), Pkb, !((k + 1 >= 10) && (k + 1 < 30)));
    end

    // Two clean presses 30 cycles apart, each held 15 cycles.
    exec_base = n_exec;
    for (int k = 0; k < 60; k++) begin
      KEY_EXEb = !((k < 15) || (k >= 30 && k < 45));
      @(negedge clk);
      check($sformatf("dbl_exec@%0d", k + 1), Exec, (k + 1 == 10) || (k + 1 == 40));
    end
    check("dbl_pulse_count", n_exec - exec_base, 2);

    // Re-press 4 cycles after release: release never qualifies, no second pulse.
    exec_base = n_exec;
    for (int k = 0; k < 45; k++) begin
      KEY_EXEb = !((k < 15) || (k >= 19));
      @(negedge clk);
      check($sformatf("repress_exec@%0d", k + 1), Exec, k + 1 == 10);
    end
    check("repress_pulse_count", n_exec - exec_base, 1);
    KEY_EXEb = 1'b1;
    step(15);

    // One-cycle reset at count=5 of a held press: pulse 10 cycles after reset falls.
    exec_base = n_exec;
    KEY_EXEb  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      rst = (k == 8);
      @(negedge clk);
      check($sformatf("midrst_exec@%0d", k + 1), Exec, k + 1 == 19);
    end
    rst = 1'b0;
    check("midrst_pulse_count", n_exec - exec_base, 1);
    KEY_EXEb = 1'b1;
    step(15);

    // Both keys pressed together: Exec pulse and Pkb fall on the same cycle.
    KEY_EXEb = 1'b0;
    KEY_PKb  = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("both_exec@%0d", k), Exec, k == 10);
      check($sformatf("both_pkb@%0d", k), Pkb, k < 10);
    end
    KEY_EXEb = 1'b1;
    KEY_PKb  = 1'b1;
    step(15);
    check("both_release_pkb", Pkb, 1'b1);
    check("both_release_active", KEY_ACTIVE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that conditions the raw board inputs feeding the processor and its output-logic probe block.
- Synchronises and debounces two active-low pushbuttons: Execute and Peek.
- Produces a one-cycle Exec pulse for the controller and a clean, glitch-free Pkb level for the output logic's DHEX mux.
- Synchronises the 10 data switches before they are driven onto the bus.

Parameters:
- DEBOUNCE_CYCLES, 50000, stable-sample count required to accept a key change (1 ms at 50 MHz); legal range >= 2.
- SYNC_STAGES, 2, flip-flop depth of every input synchroniser; legal range >= 2.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- KEY_EXEb  input  1  raw Execute pushbutton; active-low, asynchronous.
- KEY_PKb  input  1  raw Peek pushbutton; active-low, asynchronous.
- SW  input  10  raw data switches; asynchronous.
- Exec  output  1  one-cycle pulse on each accepted Execute press.
- Pkb  output  1  debounced Peek level; 1 = released (output logic shows BUS), 0 = pressed (shows REG).
- DATA  output  10  synchronised switch value.
- KEY_ACTIVE  output  1  1 while either debouncer is mid-qualification; diagnostic only.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - Exec=0, Pkb=1, DATA=0, KEY_ACTIVE=0.
  - All synchroniser flops to released level: 1 for keys, 0 for SW.
  - Both debounce FSMs to REL, counters to 0.
- Reset asserted mid-qualification aborts it. No Exec pulse is produced for a press still in progress at reset.
- Synchronisers:
  - Each key and each SW bit passes through SYNC_STAGES flops.
  - DATA equals the last stage of the SW chain. Latency is SYNC_STAGES cycles; DATA is not debounced.
- Per-key debounce FSM, using the synchronised key s and a counter of width clog2(DEBOUNCE_CYCLES+1):
  - REL: stable released.
    - s=0 goes to CHK_P with count cleared to 0.
  - CHK_P: count increments each cycle while s=0.
    - s=1 before the target returns to REL (bounce rejected).
    - count reaching DEBOUNCE_CYCLES-1 with s=0 goes to PRS.
  - PRS: stable pressed.
    - s=1 goes to CHK_R with count cleared.
  - CHK_R: mirror of CHK_P with s=1 as the qualifying level.
    - Qualifying level held goes to REL.
    - s=0 early returns to PRS.
- Timing: a press held continuously is accepted exactly DEBOUNCE_CYCLES cycles after s first reads 0. The state register updates on that edge.
- Pkb output:
  - Registered.
  - Pkb=0 while the Peek FSM is in PRS or CHK_R; otherwise 1.
  - Changes only on accepted transitions.
- Exec output:
  - Registered, asserted exactly one cycle on the edge where the Execute FSM moves CHK_P -> PRS.
  - Holding the key produces no further pulses.
  - A new pulse requires a full release qualification back to REL, then a new press qualification.
- KEY_ACTIVE = either FSM in CHK_P or CHK_R, registered.
- Counter saturation: the counter never wraps. It is cleared on every state entry and only compared against DEBOUNCE_CYCLES-1.
- Simultaneous events:
  - The two keys are fully independent; both may qualify in the same cycle.
  - Exec and a Pkb change may occur in the same cycle.
- Total Exec latency from a clean raw press = SYNC_STAGES + DEBOUNCE_CYCLES cycles.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2 for sim):
- Reset check:
  - Stimulus: rst high 3 cycles with KEY_EXEb=0 and SW=10'h3FF, then release rst.
  - Required: Exec=0, Pkb=1, DATA=0 during reset. DATA=10'h3FF 2 cycles after rst falls. No Exec pulse until KEY_EXEb has been low 8 further cycles after sync.
- Clean Execute press:
  - Stimulus: KEY_EXEb 1->0 and held 40 cycles.
  - Required: exactly one Exec=1 cycle, at 10 cycles after the raw edge. No other pulses.
- Bounce rejection:
  - Stimulus: KEY_EXEb toggles low 5 cycles / high 3 cycles, four times, then stays high.
  - Required: Exec never asserts. KEY_ACTIVE pulses during the lows. FSM ends in REL.
- Peek hold:
  - Stimulus: KEY_PKb low 20 cycles, then high.
  - Required: Pkb falls 10 cycles after the press and rises 10 cycles after the release. No glitch on a 3-cycle release bounce inserted mid-hold.
- Double press:
  - Stimulus: two clean Execute presses 30 cycles apart, each held 15 cycles.
  - Required: exactly two Exec pulses.
  - Stimulus: a second press re-asserted only 4 cycles after a release.
  - Required: no pulse, because release never qualified.
- Reset mid-qualification and simultaneity:
  - Stimulus: rst pulsed 1 cycle at count=5 during an Execute press, key held.
  - Required: no Exec until 8 fresh qualified cycles after reset.
  - Stimulus: both keys pressed in the same cycle.
  - Required: Exec pulse and Pkb fall on the same cycle.
